// File: rtl/mcu_mem_pkg.sv
// Shared definitions for the memory_32bit port and its bus masters.
package mcu_mem_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_ADDR_W = 32;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    FILL,
    FIN
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Bus-master copy/fill engine for the word-addressed memory_32bit port.
// Every output is a register; the next-state logic sets them one cycle ahead.
module mem_copy_engine
  import mcu_mem_pkg::*;
#(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [MEM_ADDR_W-1:0] src_addr,
  input  logic [MEM_ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]      len,
  input  logic [MEM_DATA_W-1:0] fill_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_done,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic                  mem_we,
  output logic [MEM_DATA_W-1:0] mem_write_data,
  input  logic [MEM_DATA_W-1:0] mem_read_data
);

  localparam logic [1:0]       LAT_INIT = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
  localparam logic [LEN_W-1:0] ONE_LEN  = LEN_W'(1);

  state_e                state_q, state_d;
  logic [MEM_ADDR_W-1:0] src_q, src_d;
  logic [MEM_ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [1:0]            lat_q, lat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_W-1:0]      words_q, words_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [MEM_DATA_W-1:0] wdata_q, wdata_d;

  logic                  last_word;
  logic                  capture;
  logic [LEN_W-1:0]      idx_nxt;

  assign last_word = (idx_q == (len_q - ONE_LEN));
  assign idx_nxt   = idx_q + ONE_LEN;
  // Read data is valid RD_LAT cycles after the RD cycle: in RD itself for a
  // combinational memory, otherwise in the last WAIT cycle.
  assign capture   = ((state_q == RD) && (RD_LAT == 0)) ||
                     ((state_q == WAIT) && (lat_q == 2'd0));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    words_d = words_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          idx_d   = '0;
          words_d = '0;
          if (len == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else if (mode == MODE_FILL) begin
            state_d = FILL;
            busy_d  = 1'b1;
            addr_d  = dst_addr;
            we_d    = 1'b1;
            wdata_d = fill_data;
          end else begin
            state_d = RD;
            busy_d  = 1'b1;
            addr_d  = src_addr;
            we_d    = 1'b0;
          end
        end
      end
      RD: begin
        if (!capture) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (!capture) begin
          lat_d = lat_q - 2'd1;
        end
      end
      WR, FILL: begin
        idx_d   = idx_nxt;
        words_d = idx_nxt;
        if (last_word) begin
          state_d = FIN;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (state_q == WR) begin
          state_d = RD;
          we_d    = 1'b0;
          addr_d  = src_q + MEM_ADDR_W'(idx_nxt);
        end else begin
          addr_d  = dst_q + MEM_ADDR_W'(idx_nxt);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      state_d = WR;
      addr_d  = dst_q + MEM_ADDR_W'(idx_q);
      we_d    = 1'b1;
      wdata_d = mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      words_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign words_done     = words_q;
  assign mem_address    = addr_q;
  assign mem_we         = we_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine against a word-level memory image model.
module tb_mem_copy_engine;
  import mcu_mem_pkg::*;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [31:0]       src_addr = '0;
  logic [31:0]       dst_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [31:0]       fill_data = '0;
  logic              busy, done, mem_we;
  logic [LEN_W-1:0]  words_done;
  logic [31:0]       mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_address(mem_address), .mem_we(mem_we),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Memory with RD_LAT-cycle registered read; low 10 address bits select the word.
  logic [31:0] mem_arr [1024];
  logic [31:0] rd_pipe [4];
  logic        poke_en = 1'b0;
  logic [31:0] poke_a = '0, poke_d = '0;
  logic [31:0] wr_log_a[$], wr_log_d[$];
  int unsigned we_bad = 0;
  logic [31:0] ref_mem [logic [31:0]];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_arr[mem_address[9:0]];
    for (int k = 1; k < 4; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_we) begin
      mem_arr[mem_address[9:0]] <= mem_write_data;
      wr_log_a.push_back(mem_address);
      wr_log_d.push_back(mem_write_data);
    end else if (poke_en) begin
      mem_arr[poke_a[9:0]] <= poke_d;
    end
  end
  assign mem_read_data = rd_pipe[RD_LAT-1];

  always @(negedge clk) if (mem_we && !busy) we_bad <= we_bad + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    poke_en = 1'b1; poke_a = a; poke_d = v;
    ref_mem[a] = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic scramble_inputs();
    mode      = 1'($urandom);
    src_addr  = $urandom;
    dst_addr  = $urandom;
    len       = LEN_W'($urandom_range(1, 20));
    fill_data = $urandom;
  endtask

  // Runs one job and checks it against the ascending-order word-copy/fill model.
  task automatic run_job(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] l, input logic [31:0] f, input bit start_busy);
    logic [31:0] ea[$], ed[$];
    logic [31:0] v, t;
    int unsigned base, bc, budget, exp_bc;
    bit          got;
    for (int unsigned i = 0; i < l; i++) begin
      v = (m == MODE_FILL) ? f : ref_rd(s + i);
      ref_mem[d + i] = v;
      ea.push_back(d + i);
      ed.push_back(v);
    end
    exp_bc = (m == MODE_FILL) ? l : l * (RD_LAT + 2);
    budget = l * (RD_LAT + 2) + 8;
    base   = wr_log_a.size();
    bc     = 0;
    got    = 1'b0;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
    for (int unsigned c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin start = 1'b0; scramble_inputs(); end
      if (start_busy && c == 1) start = 1'b1;
      if (c == 2) start = 1'b0;
      if (busy) bc++;
      if (done) begin got = 1'b1; break; end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_cycles", bc, exp_bc);
    chk("busy_at_done", busy, 0);
    chk("words_done", words_done, l);
    scramble_inputs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("start_in_fin_ignored", busy, 0);
    chk("words_done_hold", words_done, l);
    chk("write_count", wr_log_a.size() - base, ea.size());
    for (int unsigned i = 0; i < ea.size() && base + i < wr_log_a.size(); i++) begin
      chk("wr_addr", wr_log_a[base+i], ea[i]);
      chk("wr_data", wr_log_d[base+i], ed[i]);
    end
    for (int unsigned i = 0; i < l; i++) begin
      t = d + i;
      chk("mem_readback", mem_arr[t[9:0]], ref_rd(t));
    end
  endtask

  initial begin
    logic [31:0] t;
    int unsigned base;
    bit          saw_done, saw_we;
    for (int k = 0; k < 1024; k++) mem_arr[k] = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_words", words_done, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_write_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_job(MODE_FILL, 32'h0, 32'h10, 16'd4, 32'hCAFED00D, 1'b0);

    poke(32'h0, 32'hDEADBEEF);
    poke(32'h1, 32'h12345678);
    poke(32'h2, 32'hAABBCCDD);
    run_job(MODE_COPY, 32'h0, 32'h50, 16'd3, 32'h0, 1'b0);

    run_job(MODE_FILL, 32'h0, 32'h60, 16'd0, 32'h11111111, 1'b0);
    run_job(MODE_COPY, 32'h0, 32'h70, 16'd6, 32'h0, 1'b1);
    run_job(MODE_FILL, 32'h0, 32'h80, 16'd6, 32'h5A5A5A5A, 1'b1);

    run_job(MODE_FILL, 32'h0, 32'hFFFFFFFF, 16'd2, 32'h0BADF00D, 1'b0);

    for (int unsigned i = 0; i < 8; i++) poke(32'h200 + i, $urandom);
    base  = wr_log_a.size();
    start = 1'b1; mode = MODE_COPY; src_addr = 32'h200; dst_addr = 32'h280; len = 16'd8;
    for (int unsigned c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (wr_log_a.size() - base >= 2) break;
    end
    chk("rst_mid_two_writes", wr_log_a.size() - base, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", mem_we, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    saw_we   = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (mem_we) saw_we = 1'b1;
    end
    chk("rst_mid_no_done", saw_done, 0);
    chk("rst_mid_no_we", saw_we, 0);
    chk("rst_mid_write_count", wr_log_a.size() - base, 2);
    for (int unsigned i = 0; i < 2; i++) ref_mem[32'h280 + i] = ref_rd(32'h200 + i);
    for (int unsigned i = 0; i < 8; i++) begin
      t = 32'h280 + i;
      chk("rst_mid_mem", mem_arr[t[9:0]], ref_rd(t));
    end
    run_job(MODE_COPY, 32'h200, 32'h2C0, 16'd5, 32'h0, 1'b0);

    for (int unsigned i = 0; i < 128; i++) poke(32'h100 + i, $urandom);
    for (int unsigned j = 0; j < 12; j++) begin
      run_job(1'($urandom), 32'h100 + $urandom_range(0, 31), 32'h100 + $urandom_range(0, 63),
              LEN_W'($urandom_range(0, 12)), $urandom, 1'($urandom));
    end

    chk("we_outside_busy", we_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
